// File: rtl/avr_dmem_arbiter_if.sv
// avr_dmem_arbiter_if: CPU data port, auxiliary request/grant port and
// single-port data-memory port of the AVR data-memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system
// (core, auxiliary requester and memory).
interface avr_dmem_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              cpu_req;
  logic              cpu_we;
  logic [15:0]       cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_stall;

  logic              aux_req;
  logic              aux_we;
  logic [15:0]       aux_addr;
  logic [7:0]        aux_wdata;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [7:0]        aux_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/avr_dmem_arbiter.sv
// avr_dmem_arbiter: shares the registered-read data memory between the AVR
// core data port (priority) and one auxiliary requester. One access per
// cycle; read data returns one cycle after issue for either port.
// Optional starvation guard: define AVR_DMEM_ARB_STARVE_EN to let the aux
// port win after AUX_MAX_WAIT consecutive denied cycles. Without it the CPU
// has strict priority and is never stalled.
module avr_dmem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int AUX_MAX_WAIT = 8
) (
  input logic               CLK,
  input logic               RST,
  avr_dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

  owner_e            rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              cpu_win_s, aux_win_s;
  logic [ADDR_W-1:0] cpu_addr_s, aux_addr_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic              mem_we_s;
  logic [7:0]        mem_wdata_s;
  logic              unused_addr_s;

  // Requester addresses are truncated to the memory width.
  assign cpu_addr_s    = bus.cpu_addr[ADDR_W-1:0];
  assign aux_addr_s    = bus.aux_addr[ADDR_W-1:0];
  assign unused_addr_s = ^{bus.cpu_addr[15:ADDR_W], bus.aux_addr[15:ADDR_W]};

`ifdef AVR_DMEM_ARB_STARVE_EN
  localparam logic [7:0] MAX_WAIT = 8'(AUX_MAX_WAIT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       forced_s;

  assign forced_s = bus.aux_req && (wait_cnt_q == MAX_WAIT);

  // Grant: a starved aux request first, then the CPU, then aux; nothing during reset.
  always_comb begin
    cpu_win_s = 1'b0;
    aux_win_s = 1'b0;
    if (RST) begin
      cpu_win_s = 1'b0;
      aux_win_s = 1'b0;
    end else if (forced_s) begin
      aux_win_s = 1'b1;
    end else if (bus.cpu_req) begin
      cpu_win_s = 1'b1;
    end else if (bus.aux_req) begin
      aux_win_s = 1'b1;
    end else begin
      cpu_win_s = 1'b0;
      aux_win_s = 1'b0;
    end
  end

  // Count consecutive denied aux cycles, saturating; clear on grant or withdrawal.
  always_comb begin
    wait_cnt_d = 8'd0;
    if (bus.aux_req && !aux_win_s) begin
      if (wait_cnt_q == MAX_WAIT) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end else begin
      wait_cnt_d = 8'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.cpu_stall = bus.cpu_req && !cpu_win_s && !RST;
`else
  localparam int UNUSED_MAX_WAIT = AUX_MAX_WAIT;

  // Grant: strict CPU priority, aux only in CPU-idle cycles; nothing during reset.
  always_comb begin
    cpu_win_s = 1'b0;
    aux_win_s = 1'b0;
    if (RST) begin
      cpu_win_s = 1'b0;
      aux_win_s = 1'b0;
    end else if (bus.cpu_req) begin
      cpu_win_s = 1'b1;
    end else if (bus.aux_req) begin
      aux_win_s = 1'b1;
    end else begin
      cpu_win_s = 1'b0;
      aux_win_s = 1'b0;
    end
  end

  assign bus.cpu_stall = 1'b0;
`endif

  // Memory port mux: the winner drives it; idle keeps the last address, no write.
  always_comb begin
    mem_addr_s  = last_addr_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = 8'h00;
    if (cpu_win_s) begin
      mem_addr_s  = cpu_addr_s;
      mem_we_s    = bus.cpu_we;
      mem_wdata_s = bus.cpu_wdata;
    end else if (aux_win_s) begin
      mem_addr_s  = aux_addr_s;
      mem_we_s    = bus.aux_we;
      mem_wdata_s = bus.aux_wdata;
    end else begin
      mem_addr_s  = last_addr_q;
      mem_we_s    = 1'b0;
      mem_wdata_s = 8'h00;
    end
  end

  // Next read owner: whoever issued a read this cycle, otherwise nobody.
  always_comb begin
    rd_owner_d  = OWN_NONE;
    last_addr_d = mem_addr_s;
    if (cpu_win_s && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (aux_win_s && !bus.aux_we) begin
      rd_owner_d = OWN_AUX;
    end else begin
      rd_owner_d = OWN_NONE;
    end
  end

  // Read-owner and last-address registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_owner_q  <= OWN_NONE;
      last_addr_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.aux_gnt    = aux_win_s;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.aux_rvalid = (rd_owner_q == OWN_AUX);
  assign bus.aux_rdata  = (rd_owner_q == OWN_AUX) ? bus.mem_rdata : 8'h00;

endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// Testbench for avr_dmem_arbiter: vector table, directed multi-cycle
// sequences and random traffic checked against a behavioural model.
module tb_avr_dmem_arbiter;
`ifdef AVR_DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  localparam int ADDR_W = 11;
  localparam int MAXW   = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  avr_dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  avr_dmem_arbiter #(.ADDR_W(ADDR_W), .AUX_MAX_WAIT(MAXW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  // Single-port memory with registered read.
  logic [7:0] ram [0:2047];
  always @(posedge CLK) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference model state.
  logic [7:0]  ref_mem [0:2047];
  int          denied;
  logic [10:0] m_last;
  int          pend_owner;      // 0 none, 1 cpu, 2 aux
  logic [7:0]  pend_data;
  bit          m_aux_win;

  // Observations captured by cycle().
  logic        obs_gnt, obs_stall, obs_we, obs_rvalid;
  logic [10:0] obs_addr;
  logic [7:0]  obs_wdata, obs_ardata, obs_crd;

  typedef struct {
    logic        cpu_req, cpu_we; logic [15:0] cpu_addr; logic [7:0] cpu_wdata;
    logic        aux_req, aux_we; logic [15:0] aux_addr; logic [7:0] aux_wdata;
    logic        e_gnt, e_stall, e_we; logic [10:0] e_addr; logic [7:0] e_wdata;
    logic        e_rvalid, chk_crd; logic [7:0] e_crd;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [15:0] ca, input logic [7:0] cd,
                        input logic ar, input logic aw, input logic [15:0] aa, input logic [7:0] ad);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.aux_req = ar; bus.aux_we = aw; bus.aux_addr = aa; bus.aux_wdata = ad;
  endtask

  // One clock cycle: predict from the arbitration rules, check at negedge, advance model.
  task automatic cycle();
    bit          forced, cw, aw, e_we;
    logic [10:0] ca, aa, e_addr;
    logic [7:0]  e_wd;
    ca     = bus.cpu_addr[10:0];
    aa     = bus.aux_addr[10:0];
    forced = STARVE && bus.aux_req && (denied == MAXW);
    cw     = bus.cpu_req && !forced;
    aw     = forced || (bus.aux_req && !bus.cpu_req);
    e_addr = cw ? ca : (aw ? aa : m_last);
    e_we   = (cw && bus.cpu_we) || (aw && bus.aux_we);
    e_wd   = cw ? bus.cpu_wdata : (aw ? bus.aux_wdata : 8'h00);
    @(negedge CLK);
    obs_gnt = bus.aux_gnt; obs_stall = bus.cpu_stall; obs_we = bus.mem_we;
    obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata; obs_rvalid = bus.aux_rvalid;
    obs_ardata = bus.aux_rdata; obs_crd = bus.cpu_rdata;
    chk("aux_gnt", 16'(bus.aux_gnt), 16'(aw));
    chk("cpu_stall", 16'(bus.cpu_stall), 16'(bus.cpu_req && !cw));
    chk("mem_we", 16'(bus.mem_we), 16'(e_we));
    chk("mem_addr", 16'(bus.mem_addr), 16'(e_addr));
    chk("mem_wdata", 16'(bus.mem_wdata), 16'(e_wd));
    chk("aux_rvalid", 16'(bus.aux_rvalid), 16'(pend_owner == 2));
    chk("aux_rdata", 16'(bus.aux_rdata), 16'((pend_owner == 2) ? pend_data : 8'h00));
    if (pend_owner == 1) chk("cpu_rdata", 16'(bus.cpu_rdata), 16'(pend_data));
    m_aux_win = aw;
    @(posedge CLK);
    if (cw && !bus.cpu_we) begin
      pend_owner = 1; pend_data = ref_mem[ca];
    end else if (aw && !bus.aux_we) begin
      pend_owner = 2; pend_data = ref_mem[aa];
    end else begin
      pend_owner = 0;
    end
    if (e_we) ref_mem[e_addr] = e_wd;
    if (bus.aux_req && !aw) denied = (denied < MAXW) ? denied + 1 : MAXW;
    else denied = 0;
    if (cw || aw) m_last = e_addr;
    #1;
  endtask

  initial begin
    int gnt_at, stall_cnt;
    for (int i = 0; i < 2048; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
    denied = 0; m_last = 11'd0; pend_owner = 0; pend_data = 8'h00; m_aux_win = 1'b0;

    //             cpu: req we addr wdata         aux: req we addr wdata         exp: gnt stall we addr wdata rvalid chkcrd crd
    vt[0] = '{1'b1, 1'b1, 16'h0010, 8'h5A, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 11'h010, 8'h5A, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b0, 16'h0010, 8'h11, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b0, 1'b0, 11'h010, 8'h11, 1'b0, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0020, 8'hA5, 1'b1, 1'b0, 1'b1, 11'h020, 8'hA5, 1'b0, 1'b1, 8'h5A};
    vt[3] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 11'h020, 8'h00, 1'b0, 1'b0, 8'h00};
    vt[4] = '{1'b1, 1'b0, 16'hF810, 8'h33, 1'b1, 1'b1, 16'h0040, 8'h99, 1'b0, 1'b0, 1'b0, 11'h010, 8'h33, 1'b0, 1'b0, 8'h00};
    vt[5] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'hFFFF, 8'h44, 1'b1, 1'b0, 1'b0, 11'h7FF, 8'h44, 1'b0, 1'b1, 8'h5A};
    vt[6] = '{1'b1, 1'b1, 16'h07FF, 8'hC3, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 11'h7FF, 8'hC3, 1'b1, 1'b0, 8'h00};
    vt[7] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 11'h7FF, 8'h00, 1'b0, 1'b0, 8'h00};

    // Reset: requests present while RST is high must not reach memory.
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    set_in(1'b1, 1'b1, 16'h0123, 8'h77, 1'b1, 1'b1, 16'h0456, 8'h88);
    #1;
    chk("reset_cpu_stall", 16'(bus.cpu_stall), 16'd0);
    chk("reset_aux_gnt", 16'(bus.aux_gnt), 16'd0);
    chk("reset_aux_rvalid", 16'(bus.aux_rvalid), 16'd0);
    chk("reset_aux_rdata", 16'(bus.aux_rdata), 16'd0);
    chk("reset_mem_we", 16'(bus.mem_we), 16'd0);
    chk("reset_mem_addr", 16'(bus.mem_addr), 16'd0);
    chk("reset_mem_wdata", 16'(bus.mem_wdata), 16'd0);
    @(posedge CLK);
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].cpu_req, vt[i].cpu_we, vt[i].cpu_addr, vt[i].cpu_wdata,
             vt[i].aux_req, vt[i].aux_we, vt[i].aux_addr, vt[i].aux_wdata);
      cycle();
      chk($sformatf("vec%0d_gnt", i), 16'(obs_gnt), 16'(vt[i].e_gnt));
      chk($sformatf("vec%0d_stall", i), 16'(obs_stall), 16'(vt[i].e_stall));
      chk($sformatf("vec%0d_we", i), 16'(obs_we), 16'(vt[i].e_we));
      chk($sformatf("vec%0d_addr", i), 16'(obs_addr), 16'(vt[i].e_addr));
      chk($sformatf("vec%0d_wdata", i), 16'(obs_wdata), 16'(vt[i].e_wdata));
      chk($sformatf("vec%0d_rvalid", i), 16'(obs_rvalid), 16'(vt[i].e_rvalid));
      if (vt[i].chk_crd) chk($sformatf("vec%0d_cpu_rdata", i), 16'(obs_crd), 16'(vt[i].e_crd));
    end

    // CPU only: write then read back.
    set_in(1'b1, 1'b1, 16'h0010, 8'h5A, 1'b0, 1'b0, 16'h0, 8'h0); cycle();
    chk("cpu_wr_stall", 16'(obs_stall), 16'd0);
    set_in(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0); cycle();
    chk("cpu_rd_stall", 16'(obs_stall), 16'd0);
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0); cycle();
    chk("cpu_rd_after_wr", 16'(obs_crd), 16'h005A);

    // Aux only read.
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0010, 8'h00); cycle();
    chk("aux_rd_gnt", 16'(obs_gnt), 16'd1);
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0); cycle();
    chk("aux_rd_rvalid", 16'(obs_rvalid), 16'd1);
    chk("aux_rd_data", 16'(obs_ardata), 16'h005A);
    cycle();
    chk("aux_rd_rvalid_drop", 16'(obs_rvalid), 16'd0);

    // Contention: CPU requests every cycle while aux wants to write.
    set_in(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b1, 16'h0020, 8'hA5);
    gnt_at = 0; stall_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (obs_gnt && gnt_at == 0) gnt_at = k;
      if (obs_stall) stall_cnt++;
      if (obs_gnt) bus.aux_req = 1'b0;
    end
    chk("contention_gnt_cycle", 16'(gnt_at), STARVE ? 16'd9 : 16'd0);
    chk("contention_stall_count", 16'(stall_cnt), STARVE ? 16'd1 : 16'd0);
    bus.cpu_req = 1'b0; cycle();
    chk("gnt_after_cpu_drop", 16'(obs_gnt), STARVE ? 16'd0 : 16'd1);
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0); cycle();

    // Interleave: CPU read then aux read on consecutive cycles.
    set_in(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0); cycle();
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0020, 8'h00); cycle();
    chk("interleave_cpu_rdata", 16'(obs_crd), 16'h005A);
    chk("interleave_no_aux_rvalid", 16'(obs_rvalid), 16'd0);
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0); cycle();
    chk("interleave_aux_rvalid", 16'(obs_rvalid), 16'd1);
    chk("interleave_aux_rdata", 16'(obs_ardata), 16'h00A5);

    // Reset mid-read: aux read issued, RST pulsed in the following cycle.
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0010, 8'h00); cycle();
    chk("rst_pre_gnt", 16'(obs_gnt), 16'd1);
    set_in(1'b1, 1'b1, 16'h0030, 8'h77, 1'b0, 1'b0, 16'h0, 8'h0);
    #1 RST = 1'b1;
    #1;
    chk("rst_mid_rvalid", 16'(bus.aux_rvalid), 16'd0);
    chk("rst_mid_aux_rdata", 16'(bus.aux_rdata), 16'd0);
    chk("rst_mid_mem_we", 16'(bus.mem_we), 16'd0);
    chk("rst_mid_mem_addr", 16'(bus.mem_addr), 16'd0);
    chk("rst_mid_mem_wdata", 16'(bus.mem_wdata), 16'd0);
    chk("rst_mid_cpu_stall", 16'(bus.cpu_stall), 16'd0);
    @(posedge CLK); #1;
    chk("rst_hold_rvalid", 16'(bus.aux_rvalid), 16'd0);
    chk("rst_hold_mem_we", 16'(bus.mem_we), 16'd0);
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    denied = 0; m_last = 11'd0; pend_owner = 0;
    chk("rst_after_rvalid", 16'(bus.aux_rvalid), 16'd0);
    set_in(1'b1, 1'b0, 16'h0030, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0); cycle();
    set_in(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0); cycle();
    chk("no_write_during_reset", 16'(obs_crd), 16'h0000);

    // Random traffic; aux holds its request until granted.
    for (int k = 0; k < 400; k++) begin
      bus.cpu_req   = ($urandom_range(0, 9) < 6);
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = {5'($urandom), 11'($urandom_range(0, 15))};
      bus.cpu_wdata = 8'($urandom);
      if (!(bus.aux_req && !m_aux_win)) begin
        bus.aux_req   = ($urandom_range(0, 9) < 5);
        bus.aux_we    = 1'($urandom_range(0, 1));
        bus.aux_addr  = {5'($urandom), 11'($urandom_range(0, 15))};
        bus.aux_wdata = 8'($urandom);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
